// File: rtl/vball_pkg.sv
// rtl/vball_pkg.sv - sprite RAM depth, sprite byte offsets and copy FSM encoding
package vball_pkg;

    localparam int SPR_RAM_DEPTH = 256;

    localparam int SPR_OFS_Y    = 0;
    localparam int SPR_OFS_ATTR = 1;
    localparam int SPR_OFS_ID   = 2;
    localparam int SPR_OFS_X    = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_COPY = 1'b1
    } spr_state_e;

endpackage

// File: rtl/vball_spr_dpram.sv
// rtl/vball_spr_dpram.sv - byte RAM with one sync write, one async read and one registered read port
module vball_spr_dpram
    import vball_pkg::*;
#(
    parameter int DEPTH = SPR_RAM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_araddr,
    output logic [7:0]    o_ardata,
    input  logic [AW-1:0] i_sraddr,
    output logic [7:0]    o_srdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_srdata;

    // Contents are deliberately never reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read samples the array before this edge's write lands.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_srdata <= 8'h00;
        end else begin
            r_srdata <= r_mem[i_sraddr];
        end
    end

    assign o_ardata = r_mem[i_araddr];
    assign o_srdata = r_srdata;

endmodule

// File: rtl/vball_sprite_ram.sv
// rtl/vball_sprite_ram.sv - double-buffered sprite RAM with vblank-triggered work-to-display copy
module vball_sprite_ram
    import vball_pkg::*;
#(
    parameter int DEPTH = SPR_RAM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    input  logic          cpu_we,
    output logic [7:0]    cpu_dout,
    input  logic          dma_en,
    input  logic          vblank,
    input  logic [AW-1:0] sma,
    output logic [7:0]    smd,
    output logic          dma_busy,
    output logic          dma_done
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    spr_state_e    r_state;
    logic [AW-1:0] r_cnt;
    logic          r_vbl_q;
    logic          r_busy;
    logic          r_done;
    logic [7:0]    w_work_copy;
    logic [7:0]    w_disp_sync_unused;
    logic          w_copy_we;

    assign w_copy_we = (r_state == ST_COPY);

    // vbl_q resets high so a release inside vblank is not seen as a rising edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_vbl_q <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_vbl_q <= vblank;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (vblank && !r_vbl_q && dma_en) begin
                        r_state <= ST_COPY;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_COPY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Copy source is the async port, so a same-cycle CPU write is not seen by the copy.
    vball_spr_dpram #(.DEPTH(DEPTH), .AW(AW)) u_work (
        .i_clk    (clk_sys),
        .i_rst_n  (reset_n),
        .i_we     (cpu_we),
        .i_waddr  (cpu_addr),
        .i_wdata  (cpu_din),
        .i_araddr (r_cnt),
        .o_ardata (w_work_copy),
        .i_sraddr (cpu_addr),
        .o_srdata (cpu_dout)
    );

    vball_spr_dpram #(.DEPTH(DEPTH), .AW(AW)) u_display (
        .i_clk    (clk_sys),
        .i_rst_n  (reset_n),
        .i_we     (w_copy_we),
        .i_waddr  (r_cnt),
        .i_wdata  (w_work_copy),
        .i_araddr (sma),
        .o_ardata (smd),
        .i_sraddr (sma),
        .o_srdata (w_disp_sync_unused)
    );

    assign dma_busy = r_busy;
    assign dma_done = r_done;

endmodule
